// File: rtl/store_buf_pkg.sv
// Shared definitions for the store buffer: store-width encodings, bus FSM states, entry format.
package store_buf_pkg;

   localparam logic [2:0] WT_BYTE = 3'd0;
   localparam logic [2:0] WT_HALF = 3'd1;
   localparam logic [2:0] WT_WORD = 3'd2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } bus_state_t;

   typedef struct packed {
      logic [29:0] waddr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } sb_entry_t;

   function automatic logic wt_valid(input logic [2:0] wt);
      return (wt == WT_BYTE) || (wt == WT_HALF) || (wt == WT_WORD);
   endfunction

endpackage

// File: rtl/store_buf_fifo.sv
// Circular store queue; exposes every slot and its valid bit so loads can be hazard-checked.
// Push and pop take effect on the same edge they are requested; the caller guarantees no push when full.
module store_buf_fifo
   import store_buf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_push,
   input  sb_entry_t                 i_entry,
   input  logic                      i_pop,
   output sb_entry_t                 o_head,
   output sb_entry_t                 o_next,
   output sb_entry_t [DEPTH-1:0]     o_entries,
   output logic      [DEPTH-1:0]     o_valid,
   output logic      [$clog2(DEPTH):0] o_count
);

   localparam int PW = $clog2(DEPTH);

   sb_entry_t [DEPTH-1:0] r_mem;
   logic      [DEPTH-1:0] r_valid;
   logic      [PW-1:0]    r_wr_ptr;
   logic      [PW-1:0]    r_rd_ptr;
   logic      [PW:0]      r_count;
   logic      [PW-1:0]    w_rd_next;

   assign w_rd_next = r_rd_ptr + PW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem    <= '0;
         r_valid  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_pop) begin
            r_valid[r_rd_ptr] <= 1'b0;
            r_rd_ptr          <= w_rd_next;
         end
         if (i_push) begin
            r_mem[r_wr_ptr]   <= i_entry;
            r_valid[r_wr_ptr] <= 1'b1;
            r_wr_ptr          <= r_wr_ptr + PW'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head    = r_mem[r_rd_ptr];
   assign o_next    = r_mem[w_rd_next];
   assign o_entries = r_mem;
   assign o_valid   = r_valid;
   assign o_count   = r_count;

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: lane-aligns pipeline stores, queues them, and drains them one at a time to RAM.
// Optional STORE_BUF_MISALIGN_CHK_EN drops misaligned half/word stores and pulses misalign_err.
module store_buffer
   import store_buf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ram_write,
   input  logic [2:0]  write_type,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_write_data,
   input  logic        mem_read,
   output logic        stall,
   output logic        drained,
   output logic        bus_req,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_ack
`ifdef STORE_BUF_MISALIGN_CHK_EN
   ,
   output logic        misalign_err
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   bus_state_t            r_state;
   bus_state_t            w_state_nxt;
   logic [31:0]           r_bus_addr;
   logic [31:0]           r_bus_wdata;
   logic [3:0]            r_bus_wstrb;

   sb_entry_t             w_entry;
   sb_entry_t             w_head;
   sb_entry_t             w_next;
   sb_entry_t             w_load_entry;
   sb_entry_t [DEPTH-1:0] w_entries;
   logic [DEPTH-1:0]      w_valid;
   logic [CW-1:0]         w_count;
   logic                  w_store_req;
   logic                  w_full;
   logic                  w_hazard;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_load;
   logic                  w_sel_next;

   always_comb begin
      w_entry       = '0;
      w_entry.waddr = mem_addr[31:2];
      case (write_type)
         WT_BYTE: begin
            w_entry.wdata = {4{mem_write_data[7:0]}};
            w_entry.wstrb = 4'b0001 << mem_addr[1:0];
         end
         WT_HALF: begin
            w_entry.wdata = {2{mem_write_data[15:0]}};
            w_entry.wstrb = 4'b0011 << {mem_addr[1], 1'b0};
         end
         WT_WORD: begin
            w_entry.wdata = mem_write_data;
            w_entry.wstrb = 4'b1111;
         end
         default: ;
      endcase
   end

   // Every queued slot, including the one on the bus, blocks a load to the same word.
   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_valid[i] && (w_entries[i].waddr == mem_addr[31:2])) begin
            w_hazard = 1'b1;
         end
      end
      w_hazard = w_hazard & mem_read;
   end

   assign w_store_req = ram_write & wt_valid(write_type);
   assign w_full      = (w_count == CW'(DEPTH));
   assign stall       = (w_store_req & w_full) | w_hazard;
   assign drained     = (w_count == '0) && (r_state == ST_IDLE);

`ifdef STORE_BUF_MISALIGN_CHK_EN
   logic w_misaligned;
   logic r_misalign_err;

   assign w_misaligned = ((write_type == WT_HALF) && mem_addr[0]) ||
                         ((write_type == WT_WORD) && (mem_addr[1:0] != 2'b00));
   assign w_push       = w_store_req & ~stall & ~w_misaligned;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_misalign_err <= 1'b0;
      else     r_misalign_err <= w_store_req & ~stall & w_misaligned;
   end

   assign misalign_err = r_misalign_err;
`else
   assign w_push = w_store_req & ~stall;
`endif

   store_buf_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_push),
      .i_entry   (w_entry),
      .i_pop     (w_pop),
      .o_head    (w_head),
      .o_next    (w_next),
      .o_entries (w_entries),
      .o_valid   (w_valid),
      .o_count   (w_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // On ack the head is popped this edge, so the following entry sits one slot past it.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_load      = 1'b0;
      w_sel_next  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_count != '0) begin
               w_load      = 1'b1;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (bus_ack) begin
               w_pop = 1'b1;
               if (w_count > CW'(1)) begin
                  w_load     = 1'b1;
                  w_sel_next = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_load_entry = w_sel_next ? w_next : w_head;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_bus_wstrb <= '0;
      end else if (w_load) begin
         r_bus_addr  <= {w_load_entry.waddr, 2'b00};
         r_bus_wdata <= w_load_entry.wdata;
         r_bus_wstrb <= w_load_entry.wstrb;
      end
   end

   assign bus_req   = (r_state == ST_BUSY);
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;
   assign bus_wstrb = r_bus_wstrb;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: lane formation, latency, full/hazard stalls, reset abort, optional misalign check.
module tb_store_buffer;
   import store_buf_pkg::*;

   logic        clk;
   logic        rst;
   logic        ram_write;
   logic [2:0]  write_type;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic        mem_read;
   logic        stall;
   logic        drained;
   logic        bus_req;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ack;
`ifdef STORE_BUF_MISALIGN_CHK_EN
   logic        misalign_err;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   store_buffer #(.DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .ram_write      (ram_write),
      .write_type     (write_type),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read       (mem_read),
      .stall          (stall),
      .drained        (drained),
      .bus_req        (bus_req),
      .bus_addr       (bus_addr),
      .bus_wdata      (bus_wdata),
      .bus_wstrb      (bus_wstrb),
      .bus_ack        (bus_ack)
`ifdef STORE_BUF_MISALIGN_CHK_EN
      ,
      .misalign_err   (misalign_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      else             n_pass++;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic single_store(input string tag, input logic [2:0] wt, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] ea,
                               input logic [3:0] es, input logic [31:0] ed);
      ram_write = 1'b1; write_type = wt; mem_addr = a; mem_write_data = d;
      #1 chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
      tick;
      ram_write = 1'b0; write_type = 3'd7;
      chk({tag, "_req_n"}, {31'd0, bus_req}, 32'd0);
      tick;
      chk({tag, "_req_n1"}, {31'd0, bus_req}, 32'd1);
      chk({tag, "_addr"},   bus_addr, ea);
      chk({tag, "_wstrb"},  {28'd0, bus_wstrb}, {28'd0, es});
      chk({tag, "_wdata"},  bus_wdata, ed);
      bus_ack = 1'b1;
      tick;
      bus_ack = 1'b0;
      chk({tag, "_req_done"}, {31'd0, bus_req}, 32'd0);
      chk({tag, "_drained"},  {31'd0, drained}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ram_write = 1'b0; write_type = 3'd7; mem_addr = '0;
      mem_write_data = '0; mem_read = 1'b0; bus_ack = 1'b0;
      #1;
      chk("rst_req",     {31'd0, bus_req}, 32'd0);
      chk("rst_drained", {31'd0, drained}, 32'd1);
      chk("rst_stall",   {31'd0, stall},   32'd0);
      chk("rst_addr",    bus_addr,         32'd0);
      chk("rst_wstrb",   {28'd0, bus_wstrb}, 32'd0);
      tick; tick;
      rst = 1'b0;
      tick;

      single_store("sw",  WT_WORD, 32'h100, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF);
      single_store("sb",  WT_BYTE, 32'h103, 32'h000000AB, 32'h100, 4'b1000, 32'hABABABAB);
      single_store("sh",  WT_HALF, 32'h102, 32'h00001234, 32'h100, 4'b1100, 32'h12341234);

      // Invalid write_type is ignored.
      ram_write = 1'b1; write_type = 3'd3; mem_addr = 32'h500; mem_write_data = 32'h1;
      #1 chk("badwt_stall", {31'd0, stall}, 32'd0);
      tick;
      ram_write = 1'b0; write_type = 3'd7;
      tick;
      chk("badwt_req",     {31'd0, bus_req}, 32'd0);
      chk("badwt_drained", {31'd0, drained}, 32'd1);

      // Fill to DEPTH with ack held low, then the fifth store waits for a freed slot.
      for (int i = 0; i < 4; i++) begin
         ram_write = 1'b1; write_type = WT_WORD; mem_addr = 32'h300 + 32'(4 * i);
         mem_write_data = 32'hA0 + 32'(i);
         #1 chk("fill_stall", {31'd0, stall}, 32'd0);
         tick;
      end
      write_type = 3'd3; mem_addr = 32'h310; mem_write_data = 32'hA4;
      #1 chk("full_badwt_stall", {31'd0, stall}, 32'd0);
      write_type = WT_WORD;
      #1 chk("full_stall", {31'd0, stall}, 32'd1);
      tick;
      chk("full_stall_hold", {31'd0, stall}, 32'd1);
      chk("full_head_addr",  bus_addr, 32'h300);
      bus_ack = 1'b1;
      #1 chk("full_ack_stall", {31'd0, stall}, 32'd1);
      tick;
      bus_ack = 1'b0;
      chk("full_post_ack_stall", {31'd0, stall}, 32'd0);
      chk("full_post_ack_addr",  bus_addr, 32'h304);
      tick;
      ram_write = 1'b0; write_type = 3'd7;
      for (int k = 0; k < 4; k++) begin
         chk("drain_req",  {31'd0, bus_req}, 32'd1);
         chk("drain_addr", bus_addr, 32'h304 + 32'(4 * k));
         bus_ack = 1'b1;
         tick;
         bus_ack = 1'b0;
      end
      chk("drain_req_end",     {31'd0, bus_req}, 32'd0);
      chk("drain_drained_end", {31'd0, drained}, 32'd1);

      // Load hazard against a pending store.
      ram_write = 1'b1; write_type = WT_WORD; mem_addr = 32'h200; mem_write_data = 32'h77;
      tick;
      ram_write = 1'b0; write_type = 3'd7;
      mem_read = 1'b1; mem_addr = 32'h202;
      #1 chk("hz_pending", {31'd0, stall}, 32'd1);
      tick;
      chk("hz_busy", {31'd0, stall}, 32'd1);
      mem_addr = 32'h204;
      #1 chk("hz_other_word", {31'd0, stall}, 32'd0);
      mem_addr = 32'h202;
      #1 chk("hz_again", {31'd0, stall}, 32'd1);
      bus_ack = 1'b1;
      #1 chk("hz_ack_cycle", {31'd0, stall}, 32'd1);
      tick;
      bus_ack = 1'b0;
      chk("hz_freed",   {31'd0, stall},   32'd0);
      chk("hz_drained", {31'd0, drained}, 32'd1);
      mem_read = 1'b0;

      // Reset while BUSY with three entries queued.
      for (int i = 0; i < 3; i++) begin
         ram_write = 1'b1; write_type = WT_WORD; mem_addr = 32'h400 + 32'(4 * i);
         mem_write_data = 32'hC0 + 32'(i);
         tick;
      end
      ram_write = 1'b0; write_type = 3'd7;
      chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
      mem_read = 1'b1; mem_addr = 32'h404;
      #1 chk("pre_rst_hz", {31'd0, stall}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_req",     {31'd0, bus_req}, 32'd0);
      chk("arst_drained", {31'd0, drained}, 32'd1);
      chk("arst_stall",   {31'd0, stall},   32'd0);
      chk("arst_addr",    bus_addr,         32'd0);
      tick; tick;
      rst = 1'b0; mem_read = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("post_rst_req",     {31'd0, bus_req}, 32'd0);
         chk("post_rst_drained", {31'd0, drained}, 32'd1);
      end

`ifdef STORE_BUF_MISALIGN_CHK_EN
      ram_write = 1'b1; write_type = WT_WORD; mem_addr = 32'h101; mem_write_data = 32'h55;
      #1 chk("mis_stall", {31'd0, stall}, 32'd0);
      tick;
      ram_write = 1'b0; write_type = 3'd7;
      chk("mis_err",     {31'd0, misalign_err}, 32'd1);
      chk("mis_req",     {31'd0, bus_req},      32'd0);
      chk("mis_drained", {31'd0, drained},      32'd1);
      tick;
      chk("mis_err_clr",  {31'd0, misalign_err}, 32'd0);
      chk("mis_req2",     {31'd0, bus_req},      32'd0);
      chk("mis_drained2", {31'd0, drained},      32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port ram_write, input, 1, pipeline store request from the MEM stage.
REQ-005 SHALL have port write_type, input, 3, store width: 0 byte, 1 half, 2 word; any other value means no store.
REQ-006 SHALL have port mem_addr, input, 32, byte address of the load or store.
REQ-007 SHALL have port mem_write_data, input, 32, store data, right-aligned.
REQ-008 SHALL have port mem_read, input, 1, pipeline load request at mem_addr.
REQ-009 SHALL have port stall, output, 1, hold request to the pipeline hazard unit.
REQ-010 SHALL have port drained, output, 1, high when the buffer is empty and the bus is idle.
REQ-011 SHALL have ports bus_req (output, 1), bus_addr (output, 32, word-aligned), bus_wdata (output, 32) and bus_wstrb (output, 4), forming the RAM write request.
REQ-012 SHALL have port bus_ack, input, 1, RAM write accept.

Function
REQ-013 SHALL enqueue {word address, lane-shifted data, strobe} on a rising edge where ram_write=1, write_type is 0..2 and stall=0.
REQ-014 SHALL form the strobe as follows: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-015 SHALL replicate the data across lanes: a byte on all 4 lanes, a half on both halves.
REQ-016 SHALL run a bus FSM with states IDLE and BUSY.
REQ-017 IDLE->BUSY SHALL occur when the FIFO is non-empty; the head is latched into registered bus_* and bus_req=1.
REQ-018 In BUSY, bus_addr, bus_wdata and bus_wstrb SHALL remain stable until bus_ack.
REQ-019 On bus_ack, the FSM SHALL pop the head. If another entry remains, it stays BUSY and presents that entry the next cycle; otherwise it goes to IDLE with bus_req=0.
REQ-020 The head SHALL count as occupied until it is popped.
REQ-021 Latency: a store enqueued at edge N into an empty buffer SHALL give bus_req=1 after edge N+1; ack at edge M SHALL free its slot at edge M.
REQ-022 Full: stall SHALL equal 1 while count==DEPTH and ram_write=1; a simultaneous pop SHALL NOT admit a new store in that cycle.
REQ-023 Load hazard: stall SHALL equal 1 when mem_read=1 and mem_addr[31:2] matches any occupied entry's word address.
REQ-024 stall and drained SHALL be combinational from registered state and the current inputs.
REQ-025 The count SHALL be unchanged on a simultaneous enqueue and pop, and pointers SHALL wrap modulo DEPTH.
REQ-026 An invalid write_type SHALL be ignored with no enqueue and no stall.

Reset
REQ-027 While rst=1, the block SHALL immediately and asynchronously set all entries invalid, pointers and count to 0, FSM to IDLE, bus_req=0, bus_addr, bus_wdata and bus_wstrb to 0, stall=0 and drained=1.
REQ-028 Reset during BUSY SHALL abandon the in-flight store without waiting for bus_ack.

Configuration
REQ-029 Macro STORE_BUF_MISALIGN_CHK_EN, when defined, SHALL add output misalign_err (1 bit).
REQ-030 With the macro defined, a half store at addr[0]=1 or a word store at addr[1:0]!=0 SHALL NOT be enqueued, and misalign_err SHALL pulse high for one cycle after that edge.
REQ-031 Without the macro, misaligned stores SHALL be enqueued with the address low bits ignored for alignment (half uses addr[1], word uses lane 0), and the port SHALL be absent.

Structure
REQ-032 The shared package SHALL hold the write_type encodings (WT_BYTE, WT_HALF, WT_WORD) and the FSM state encoding.
REQ-033 The FIFO storage and pointers SHALL be one sub-module, store_buf_fifo; strobe/lane formation and the FSM SHALL live in store_buffer.

Verification
REQ-034 Bench SHALL drive SW addr 0x100 data 0xDEADBEEF with ack after 1 cycle, and check bus_req the next cycle with addr 0x100, wstrb 1111, wdata 0xDEADBEEF.
REQ-035 Bench SHALL drive SB addr 0x103 data 0x000000AB, and check wstrb 1000 and wdata 0xABABABAB; also SH addr 0x102 data 0x1234, and check wstrb 1100 and wdata 0x12341234.
REQ-036 Bench SHALL drive 5 SW stores with bus_ack held 0, and check that the 5th sees stall=1 and that after one ack it enqueues the following cycle, never simultaneously.
REQ-037 Bench SHALL drive SW 0x200 pending and then a load at 0x202, and check stall=1 until the ack for 0x200, while a load at 0x204 gives stall=0.
REQ-038 Bench SHALL assert rst while BUSY with 3 entries, and check bus_req=0 and drained=1 immediately, and no bus_req after release.
REQ-039 With STORE_BUF_MISALIGN_CHK_EN defined, bench SHALL drive SW addr 0x101, and check a misalign_err pulse, no bus_req and drained held at 1.
